// File: rtl/branch_compare_pipe_pkg.sv
// Shared processor package: base opcode definitions and the branch-compare
// mode encoding used by the compare pipeline.
package branch_compare_pipe_pkg;

    // Base opcodes (bits [6:0] of the instruction word).
    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_OPIMM  = 7'b0010011,
        OP_AUIPC  = 7'b0010111,
        OP_STORE  = 7'b0100011,
        OP_OP     = 7'b0110011,
        OP_LUI    = 7'b0110111,
        OP_BRANCH = 7'b1100011,
        OP_JALR   = 7'b1100111,
        OP_JAL    = 7'b1101111
    } opcode_e;

    localparam int unsigned MODE_W = 3;

    // Branch compare modes; the two top encodings are reserved and illegal.
    typedef enum logic [MODE_W-1:0] {
        CMP_EQ   = 3'd0,
        CMP_NE   = 3'd1,
        CMP_LT   = 3'd2,
        CMP_GE   = 3'd3,
        CMP_LTU  = 3'd4,
        CMP_GEU  = 3'd5,
        CMP_RSV6 = 3'd6,
        CMP_RSV7 = 3'd7
    } cmp_mode_e;

    function automatic logic mode_is_legal(input logic [MODE_W-1:0] m);
        return (m != CMP_RSV6) && (m != CMP_RSV7);
    endfunction

endpackage

// File: rtl/branch_compare_pipe_cmp_core.sv
// cmp_core: purely combinational branch comparator.
//   a, b    : operands, WIDTH bits (two's complement for signed modes)
//   mode    : compare mode (cmp_mode_e encoding)
//   taken   : compare outcome, forced 0 for illegal modes
//   illegal : 1 when mode is a reserved encoding
module cmp_core
    import branch_compare_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [MODE_W-1:0] mode,
    output logic              taken,
    output logic              illegal
);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (cmp_mode_e'(mode))
            CMP_EQ:  taken = (a == b);
            CMP_NE:  taken = (a != b);
            CMP_LT:  taken = ($signed(a) <  $signed(b));
            CMP_GE:  taken = ($signed(a) >= $signed(b));
            CMP_LTU: taken = (a <  b);
            CMP_GEU: taken = (a >= b);
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_compare_pipe.sv
// branch_compare_pipe: two-stage valid/ready branch compare pipeline.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : request handshake for reg1, reg2, mode
//   flush               : drop everything in flight at the next edge
//   out_valid/out_ready : result handshake for taken, illegal
//   taken_cnt           : saturating count of consumed taken results
// S1 registers the operands and mode; S2 registers the cmp_core outcome.
module branch_compare_pipe
    import branch_compare_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  reg1,
    input  logic [WIDTH-1:0]  reg2,
    input  logic [MODE_W-1:0] mode,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              taken,
    output logic              illegal,
    output logic [CNT_W-1:0]  taken_cnt
);

    logic              s1_valid;
    logic [WIDTH-1:0]  s1_a;
    logic [WIDTH-1:0]  s1_b;
    logic [MODE_W-1:0] s1_mode;

    logic              s2_valid;
    logic              s2_taken;
    logic              s2_illegal;

    logic              cmp_taken;
    logic              cmp_illegal;

    logic              s1_adv;
    logic              s2_adv;
    logic              consume;
    logic [CNT_W-1:0]  cnt_q;

    // S2 frees up when empty or when its result leaves this cycle; S1 frees
    // up when empty or when it can move into S2. in_ready is therefore a
    // combinational function of out_ready.
    assign s2_adv   = !s2_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign consume  = s2_valid && out_ready;

    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;
    assign taken     = s2_taken;
    assign illegal   = s2_illegal;
    assign taken_cnt = cnt_q;

    cmp_core #(
        .WIDTH(WIDTH)
    ) u_cmp (
        .a      (s1_a),
        .b      (s1_b),
        .mode   (s1_mode),
        .taken  (cmp_taken),
        .illegal(cmp_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_mode  <= '0;
        end else begin
            if (flush) begin
                s1_valid <= 1'b0;
            end else if (s1_adv) begin
                s1_valid <= in_valid;
            end
            if (s1_adv && in_valid) begin
                s1_a    <= reg1;
                s1_b    <= reg2;
                s1_mode <= mode;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid   <= 1'b0;
            s2_taken   <= 1'b0;
            s2_illegal <= 1'b0;
        end else begin
            if (flush) begin
                s2_valid <= 1'b0;
            end else if (s2_adv) begin
                s2_valid <= s1_valid;
            end
            if (s2_adv && s1_valid) begin
                s2_taken   <= cmp_taken;
                s2_illegal <= cmp_illegal;
            end
        end
    end

    // A result consumed alongside flush still counts: flush only affects
    // what has not yet been delivered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (consume && s2_taken && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_compare_pipe.sv
// Scoreboard bench for branch_compare_pipe (WIDTH=16, CNT_W=2).
module tb_branch_compare_pipe;

    localparam int W     = 16;
    localparam int CW    = 2;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  reg1 = '0;
    logic [W-1:0]  reg2 = '0;
    logic [2:0]    mode = '0;
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          taken;
    logic          illegal;
    logic [CW-1:0] taken_cnt;

    branch_compare_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .reg1     (reg1),
        .reg2     (reg2),
        .mode     (mode),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .taken    (taken),
        .illegal  (illegal),
        .taken_cnt(taken_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] exp;   // {taken, illegal}
        int         cyc;
        bit         fixed;
    } item_t;

    item_t q[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    cyc      = 0;
    int    exp_cnt  = 0;
    bit    fixed_lat = 1'b0;
    bit    prev_hold = 1'b0;
    logic [1:0] prev_ti = '0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    endtask

    // Reference comparison from the mode rules, via plain integer arithmetic.
    function automatic logic [1:0] ref_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [2:0] m);
        longint ua = a;
        longint ub = b;
        longint sa = a[W-1] ? ua - (longint'(1) << W) : ua;
        longint sb = b[W-1] ? ub - (longint'(1) << W) : ub;
        case (m)
            3'd0: return {ua == ub, 1'b0};
            3'd1: return {ua != ub, 1'b0};
            3'd2: return {sa <  sb, 1'b0};
            3'd3: return {sa >= sb, 1'b0};
            3'd4: return {ua <  ub, 1'b0};
            3'd5: return {ua >= ub, 1'b0};
            default: return 2'b01;
        endcase
    endfunction

    // Monitor / scoreboard: observes handshakes, pushes on accept, pops on consume.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 1);
            chk("rst_taken_cnt", taken_cnt, 0);
            q.delete();
            exp_cnt   = 0;
            prev_hold = 1'b0;
        end else begin
            chk("taken_cnt", taken_cnt, exp_cnt);
            if (prev_hold) begin
                chk("hold_out_valid", out_valid, 1);
                chk("hold_result", {taken, illegal}, prev_ti);
            end
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_out_valid", out_valid, 0);
                end else if (out_ready) begin
                    item_t it;
                    it = q.pop_front();
                    chk("result_taken_illegal", {taken, illegal}, it.exp);
                    if (it.fixed) chk("latency", cyc - it.cyc, 2);
                    else          chk("latency_min", (cyc - it.cyc >= 2) ? 1 : 0, 1);
                    if (it.exp[1] && exp_cnt < CMAX) exp_cnt++;
                end
            end
            prev_hold = out_valid && !out_ready && !flush;
            prev_ti   = {taken, illegal};
            if (flush) begin
                q.delete();
            end else if (in_valid && in_ready) begin
                item_t ni;
                ni.exp   = ref_cmp(reg1, reg2, mode);
                ni.cyc   = cyc;
                ni.fixed = fixed_lat;
                q.push_back(ni);
            end
        end
    end

    // Present one request and hold it until accepted (bounded).
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] m, input bit exp_rdy);
        bit acc = 1'b0;
        int n = 0;
        reg1 = a; reg2 = b; mode = m; in_valid = 1'b1;
        while (!acc && n < 20) begin
            @(negedge clk);
            acc = in_ready;
            if (exp_rdy) chk("in_ready_high", in_ready, 1);
            @(posedge clk); #1;
            n++;
        end
        if (!acc) chk("send_timeout", acc, 1);
        in_valid = 1'b0;
    endtask

    // Reset asserted mid-cycle; outputs must clear without a clock edge.
    task automatic do_reset();
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_taken_cnt", taken_cnt, 0);
        in_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        @(posedge clk); #2;
        rst_n = 1'b1;
    endtask

    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'h8000;
            2: return 16'h7FFF;
            3: return 16'hFFFF;
            4: return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int cnt_tbl[5];
        int acc_cnt;
        int idx;
        int snap;
        bit took;
        logic [W-1:0] bp_a[3];
        logic [W-1:0] bp_b[3];
        logic [2:0]   bp_m[3];

        cnt_tbl = '{1, 2, 3, 3, 3};
        bp_a = '{16'h8000, 16'h0005, 16'h0001};
        bp_b = '{16'h0001, 16'h0005, 16'h0002};
        bp_m = '{3'd3, 3'd1, 3'd4};

        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Signed vs unsigned vs equality on the same operands, out_ready held.
        fixed_lat = 1'b1;
        out_ready = 1'b1;
        send(16'h8000, 16'h0001, 3'd2, 1'b1);
        send(16'h8000, 16'h0001, 3'd4, 1'b1);
        send(16'h8000, 16'h0001, 3'd0, 1'b1);
        repeat (4) @(posedge clk); #1;

        // Back-to-back throughput.
        for (int i = 0; i < 4; i++)
            send(rand_op(), rand_op(), 3'($urandom_range(0, 5)), 1'b1);
        repeat (4) @(posedge clk); #1;

        // Backpressure: 3 offered over 5 stalled cycles.
        fixed_lat = 1'b0;
        out_ready = 1'b0;
        idx = 0; acc_cnt = 0;
        reg1 = bp_a[0]; reg2 = bp_b[0]; mode = bp_m[0]; in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            took = in_ready;
            if (took) acc_cnt++;
            @(posedge clk); #1;
            if (took) begin
                idx++;
                if (idx < 3) begin
                    reg1 = bp_a[idx]; reg2 = bp_b[idx]; mode = bp_m[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        chk("bp_accepted", acc_cnt, 2);
        @(negedge clk);
        chk("bp_in_ready_low", in_ready, 0);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk); #1;

        // Flush with both stages full and a new request offered.
        out_ready = 1'b0;
        send(16'h0007, 16'h0007, 3'd0, 1'b0);
        send(16'h0009, 16'h0009, 3'd0, 1'b0);
        snap = exp_cnt;
        reg1 = 16'h0003; reg2 = 16'h0003; mode = 3'd0;
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", out_valid, 0);
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("flush_taken_cnt", taken_cnt, snap);
        @(posedge clk); #1;

        // Illegal mode with equal operands.
        fixed_lat = 1'b1;
        send(16'h1234, 16'h1234, 3'd7, 1'b1);
        send(16'h1234, 16'h1234, 3'd6, 1'b1);
        repeat (4) @(posedge clk); #1;

        // Counter saturation from a clean start, then reset mid-stream.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            send(16'(k * 3), 16'(k * 3), 3'd0, 1'b1);
            repeat (3) @(negedge clk);
            chk("cnt_sequence", taken_cnt, cnt_tbl[k]);
            @(posedge clk); #1;
        end
        send(16'h00AA, 16'h00AA, 3'd0, 1'b1);
        send(16'h00BB, 16'h00BB, 3'd0, 1'b1);
        do_reset();

        // Randomised traffic with flushes, stalls and periodic resets.
        fixed_lat = 1'b0;
        for (int blk = 0; blk < 6; blk++) begin
            repeat (60) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                reg1      = rand_op();
                reg2      = ($urandom_range(0, 1) != 0) ? reg1 : rand_op();
                mode      = 3'($urandom_range(0, 7));
                out_ready = ($urandom_range(0, 3) != 0);
                flush     = ($urandom_range(0, 24) == 0);
                @(posedge clk); #1;
            end
            in_valid = 1'b0; flush = 1'b0;
            if (blk != 5) do_reset();
        end

        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("drain_empty", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
